apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, which sets the maximum number of ACCESS cycles to wait for PREADY (used only with APB_TIMEOUT_EN).
REQ-002 SHALL have port PCLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port PRESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid, input, 1 bit (N=0,1): requester N has a transfer pending.
REQ-005 SHALL have ports reqN_write, input, 1 bit: 1 = write, 0 = read.
REQ-006 SHALL have ports reqN_addr, input, 32 bits: transfer address.
REQ-007 SHALL have ports reqN_wdata, input, 32 bits: write data.
REQ-008 SHALL have ports reqN_ready, output, 1 bit: one-cycle accept pulse; request fields captured this cycle.
REQ-009 SHALL have ports reqN_done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have ports reqN_rdata, output, 32 bits: read data, valid while reqN_done=1.
REQ-011 SHALL have ports reqN_err, output, 1 bit: error status, valid while reqN_done=1.
REQ-012 SHALL have APB master outputs PSEL (1), PENABLE (1), PADDR (32), PWRITE (1) and PWDATA (32), all registered.
REQ-013 SHALL have APB master inputs PREADY (1), PRDATA (32) and PSLVERR (1).

Function
REQ-014 SHALL use an FSM with states IDLE, SETUP and ACCESS.
REQ-015 In IDLE with any reqN_valid=1, SHALL grant one requester, pulse its reqN_ready, latch write/addr/wdata, and enter SETUP.
REQ-016 In SETUP, SHALL drive PSEL=1, PENABLE=0 with latched PADDR/PWRITE/PWDATA, then unconditionally enter ACCESS.
REQ-017 In ACCESS, SHALL drive PSEL=1, PENABLE=1 with PADDR/PWRITE/PWDATA stable; it SHALL stay in ACCESS while PREADY=0.
REQ-018 On the edge where PREADY=1 is sampled in ACCESS, SHALL capture PRDATA (reads only) and PSLVERR, enter IDLE, and pulse the granted reqN_done for one cycle with reqN_err=PSLVERR.
REQ-019 Minimum latency: valid in cycle 0, ready in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, done in cycle 3 with zero wait states; one IDLE cycle minimum between transfers.
REQ-020 Arbitration SHALL be round-robin: when both are valid, grant the requester not granted last; after reset req0 has priority.
REQ-021 A single valid requester SHALL be granted regardless of history.
REQ-022 Deassertion of reqN_valid or changes to request fields after acceptance SHALL NOT affect the in-flight transfer.
REQ-023 reqN_rdata SHALL hold its last captured value; it is 0 for writes.
REQ-024 PSEL=0 and PENABLE=0 SHALL hold in IDLE; PADDR/PWRITE/PWDATA SHALL hold their last values.
REQ-025 Addresses SHALL be passed through unchecked; range errors are reported only via PSLVERR.

Reset
REQ-026 PRESET=1 SHALL immediately force IDLE, PSEL=0, PENABLE=0, all reqN_ready/done/err=0, all rdata=0, PADDR=0, PWRITE=0, PWDATA=0, and the round-robin pointer to favour req0.
REQ-027 Reset during SETUP/ACCESS SHALL abort the transfer with no reqN_done issued.
REQ-028 The first grant SHALL occur in the first IDLE cycle after PRESET deasserts.

Configuration
REQ-029 With macro APB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles; if TIMEOUT_CYC cycles pass with PREADY=0, the block SHALL enter IDLE, pulse reqN_done with reqN_err=1 and reqN_rdata=32'hDEADBEEF.
REQ-030 Without APB_TIMEOUT_EN, the counter SHALL be absent and ACCESS SHALL wait for PREADY indefinitely.

Verification
REQ-031 Single write: req0 write addr=5, wdata=0xA5A5A5A5, PREADY=1 -> SETUP in cycle 1, ACCESS in cycle 2, req0_done in cycle 3, req0_err=0.
REQ-032 Read-back: req1 read addr=5 -> req1_rdata=0xA5A5A5A5, req1_err=0.
REQ-033 Contention: both valid continuously after reset -> grants alternate 0,1,0,1; each done carries the correct requester's data.
REQ-034 Wait states and error: PREADY held 0 for 3 ACCESS cycles, PSLVERR=1 -> PADDR stable throughout, done 3 cycles later than nominal, err=1.
REQ-035 Reset mid-ACCESS: PRESET pulsed -> PSEL/PENABLE=0 immediately, no done; the next request is granted to req0.
REQ-036 With APB_TIMEOUT_EN and TIMEOUT_CYC=4, PREADY stuck at 0 -> done after 4 ACCESS cycles, err=1, rdata=0xDEADBEEF.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: two-requester round-robin front end for a single APB master.
//
// A requester with a pending transfer is accepted in IDLE (reqN_ready pulses
// in the same cycle and the request fields are latched). The block then runs
// the APB SETUP and ACCESS phases and reports completion with a one-cycle
// reqN_done pulse that carries reqN_err. Read data is kept in reqN_rdata
// until the next completion for that requester.
//
// Ports
//   PCLK, PRESET             clock, asynchronous active-high reset
//   reqN_valid/write/addr/wdata   request from requester N (N = 0, 1)
//   reqN_ready               accept pulse; fields are captured this cycle
//   reqN_done/err/rdata      completion pulse, error status, read data
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA   registered APB master outputs
//   PREADY/PRDATA/PSLVERR    APB slave response
//
// Optional feature: define APB_TIMEOUT_EN to bound the ACCESS phase to
// TIMEOUT_CYC cycles; an expired transfer completes with err=1 and
// rdata=32'hDEADBEEF. Without it, ACCESS waits for PREADY indefinitely.
module apb_req_arbiter #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_done,
  output logic [31:0] req0_rdata,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [31:0] req1_rdata,
  output logic        req1_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic [31:0] PRDATA,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;     // requester owning the in-flight transfer
  logic        last_q, last_d;   // requester granted most recently
  logic        psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic [1:0]  done_q, done_d, err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]  ready;
  logic        pick;
  logic        timeout;
  logic [31:0] fin_rdata;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (state_q == ACCESS) cnt_d = cnt_q + 1'b1;
  end

  // cnt_q holds the number of ACCESS cycles already spent, so the last
  // permitted cycle is cnt_q == TIMEOUT_CYC-1; a PREADY there still wins.
  assign timeout = (state_q == ACCESS) && !PREADY && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYC > 0);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    done_d    = '0;
    err_d     = '0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    ready     = '0;
    fin_rdata = '0;
    // Both valid: take the one not served last. One valid: take it.
    pick      = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          ready[pick] = 1'b1;
          gnt_d       = pick;
          last_d      = pick;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = pick ? req1_write : req0_write;
          paddr_d     = pick ? req1_addr  : req0_addr;
          pwdata_d    = pick ? req1_wdata : req0_wdata;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY || timeout) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
          done_d[gnt_q] = 1'b1;
          err_d[gnt_q]  = timeout ? 1'b1 : PSLVERR;
          if (timeout)       fin_rdata = 32'hDEADBEEF;
          else if (!pwrite_q) fin_rdata = PRDATA;
          if (gnt_q) rdata1_d = fin_rdata;
          else       rdata0_d = fin_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;   // "req1 was last" so req0 wins the first tie
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PADDR      = paddr_q;
  assign PWRITE     = pwrite_q;
  assign PWDATA     = pwdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: an APB slave with an 8-word memory, programmable
// wait states and an error region (PADDR[31]=1), plus a transaction-level
// reference (round-robin pick, reference memory, expected completion cycle).
module tb_apb_req_arbiter;

  localparam int TO = 4;

  logic        PCLK, PRESET;
  logic        req0_valid, req0_write, req0_ready, req0_done, req0_err;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_write, req1_ready, req1_done, req1_err;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;

  apb_req_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // ---------------- APB slave ----------------
  int          wait_n = 0;
  int          acc_cnt = 0;
  logic [31:0] smem [8] = '{default: 32'h0};

  assign PREADY  = PSEL && PENABLE && (acc_cnt == wait_n);
  assign PRDATA  = smem[PADDR[2:0]];
  assign PSLVERR = PADDR[31];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) smem[PADDR[2:0]] <= PWDATA;
  end

  // ---------------- reference state ----------------
  int          nchk = 0, nerr = 0;
  bit          pend [2];
  bit          pw   [2];
  logic [31:0] pa   [2];
  logic [31:0] pd   [2];
  int          last_g = 1;
  logic [31:0] ref_mem [8];
  logic [31:0] exp_rd  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    req0_valid = pend[0]; req0_write = pw[0]; req0_addr = pa[0]; req0_wdata = pd[0];
    req1_valid = pend[1]; req1_write = pw[1]; req1_addr = pa[1]; req1_wdata = pd[1];
  endtask

  task automatic set_req(input int n, input bit wr, input logic [31:0] a, input logic [31:0] d);
    pend[n] = 1'b1; pw[n] = wr; pa[n] = a; pd[n] = d;
  endtask

  // Runs one transfer from acceptance to completion. Called at a negedge
  // while the DUT is idle. keep=1 leaves the granted requester asserted;
  // to=1 expects an ACCESS timeout instead of a PREADY completion.
  task automatic do_txn(input int w, input bit keep, input bit to);
    int g, k, exp_k;
    bit e;
    logic [31:0] erd, ea, ewd;
    bit ewr;
    wait_n = w;
    drive_reqs();
    #1;
    g = (pend[0] && pend[1]) ? 1 - last_g : (pend[1] ? 1 : 0);
    chk("ready0", {31'b0, req0_ready}, {31'b0, g == 0});
    chk("ready1", {31'b0, req1_ready}, {31'b0, g == 1});
    last_g = g;
    ea = pa[g]; ewd = pd[g]; ewr = pw[g];
    if (to) begin
      e = 1'b1; erd = 32'hDEADBEEF; exp_k = 2 + TO;
    end else begin
      e = ea[31]; erd = ewr ? 32'h0 : ref_mem[ea[2:0]]; exp_k = 3 + w;
      if (ewr && !e) ref_mem[ea[2:0]] = ewd;
    end
    @(posedge PCLK); #1;
    if (!keep) begin
      // Withdraw and scramble the accepted request; the transfer must not care.
      pend[g] = 1'b0; pw[g] = ~pw[g]; pa[g] = $urandom; pd[g] = $urandom;
      drive_reqs();
    end
    @(negedge PCLK);
    chk("setup_ctl",  {30'b0, PSEL, PENABLE}, 32'b10);
    chk("setup_addr", PADDR, ea);
    chk("setup_wr",   {31'b0, PWRITE}, {31'b0, ewr});
    chk("setup_wd",   PWDATA, ewd);
    k = 1;
    while (k < 40) begin
      @(posedge PCLK); @(negedge PCLK);
      k++;
      if (req0_done || req1_done) break;
      chk("acc_ctl",  {30'b0, PSEL, PENABLE}, 32'b11);
      chk("acc_addr", PADDR, ea);
    end
    chk("done_cyc", k, exp_k);
    chk("done0", {31'b0, req0_done}, {31'b0, g == 0});
    chk("done1", {31'b0, req1_done}, {31'b0, g == 1});
    chk("err", {31'b0, (g == 1) ? req1_err : req0_err}, {31'b0, e});
    exp_rd[g] = erd;
    chk("rdata0", req0_rdata, exp_rd[0]);
    chk("rdata1", req1_rdata, exp_rd[1]);
    chk("idle_ctl", {30'b0, PSEL, PENABLE}, 32'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    for (int n = 0; n < 2; n++) begin
      pend[n] = 1'b0; pw[n] = 1'b0; pa[n] = 32'h0; pd[n] = 32'h0;
    end
    drive_reqs();
    PRESET = 1'b1;

    // Reset state
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_ctl",   {29'b0, PSEL, PENABLE, PWRITE}, 32'b0);
    chk("rst_addr",  PADDR, 32'h0);
    chk("rst_wdata", PWDATA, 32'h0);
    chk("rst_rd0",   req0_rdata, 32'h0);
    chk("rst_rd1",   req1_rdata, 32'h0);
    chk("rst_hs", {26'b0, req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err}, 32'b0);
    @(posedge PCLK); #1 PRESET = 1'b0;
    @(negedge PCLK);

    // Single write, zero wait states
    set_req(0, 1'b1, 32'd5, 32'hA5A5A5A5);
    do_txn(0, 1'b0, 1'b0);
    // Read-back by the other requester
    set_req(1, 1'b0, 32'd5, 32'h0);
    do_txn(0, 1'b0, 1'b0);
    // Three wait states on an erroring address
    set_req(0, 1'b0, 32'h8000_0005, 32'h0);
    do_txn(3, 1'b0, 1'b0);

    // Reset in the middle of ACCESS: no done, and req0 favoured afterwards
    set_req(0, 1'b0, 32'd3, 32'h0);
    wait_n = 10;
    drive_reqs();
    @(posedge PCLK); #1;
    pend[0] = 1'b0; drive_reqs();
    @(posedge PCLK); @(posedge PCLK); @(negedge PCLK);
    chk("pre_rst_acc", {30'b0, PSEL, PENABLE}, 32'b11);
    #1 PRESET = 1'b1;
    #1 chk("rst_async", {30'b0, PSEL, PENABLE}, 32'b0);
    @(posedge PCLK); #1 PRESET = 1'b0;
    last_g = 1; exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge PCLK);
      chk("no_done", {30'b0, req0_done, req1_done}, 32'b0);
    end

    // Contention: both held valid -> 0,1,0,1
    set_req(0, 1'b1, 32'd2, 32'h12345678);
    set_req(1, 1'b0, 32'd2, 32'h0);
    for (int t = 0; t < 4; t++) do_txn(0, 1'b1, 1'b0);
    pend[0] = 1'b0; pend[1] = 1'b0; drive_reqs();
    @(negedge PCLK);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      for (int n = 0; n < 2; n++)
        if (!pend[n] && $urandom_range(0, 1) == 1)
          set_req(n, 1'($urandom_range(0, 1)),
                  {($urandom_range(0, 7) == 0), 28'h0, 3'($urandom_range(0, 7))}, $urandom);
      if (!pend[0] && !pend[1])
        set_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                {1'b0, 28'h0, 3'($urandom_range(0, 7))}, $urandom);
      do_txn(int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

`ifdef APB_TIMEOUT_EN
    // PREADY never comes: completion after TO ACCESS cycles
    pend[0] = 1'b0; pend[1] = 1'b0;
    set_req(0, 1'b0, 32'd1, 32'h0);
    do_txn(1000, 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
